red_pitaya_pwm_capture: RTL and testbench

PWM input decoder, the receive-side counterpart of the board PWM generator. It samples an external PWM line, deglitches it, and measures period and high time in clk cycles. It converts the high/period ratio into a DUTY_W-bit duty word, so firmware and loopback tests can read back what the generator drives. The block sits on the housekeeping/extension-connector path, and its outputs feed status registers.

---
 rtl/red_pitaya_pwm_pkg.sv | 22 ++
 rtl/red_pitaya_pwm_capture_if.sv | 29 ++
 rtl/red_pitaya_pwm_div.sv | 85 ++++++++
 rtl/red_pitaya_pwm_capture.sv | 205 ++++++++++++++++++++
 tb/tb_red_pitaya_pwm_capture.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/red_pitaya_pwm_pkg.sv
// Shared types and defaults for the PWM generator/capture pair.
package red_pitaya_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } pwm_cap_state_t;

    localparam int PWM_CW     = 24;
    localparam int PWM_DUTY_W = 8;
    localparam int PWM_FW     = 4;

    // All-ones value of a width-bit saturating counter (width <= 32).
    function automatic logic [31:0] pwm_sat_val(input int width);
        if (width >= 32) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/red_pitaya_pwm_capture_if.sv
// Signal bundle between the PWM capture block and its status-register host.
interface red_pitaya_pwm_capture_if
    import red_pitaya_pwm_pkg::*;
#(
    parameter int CW     = PWM_CW,
    parameter int DUTY_W = PWM_DUTY_W,
    parameter int FW     = PWM_FW
);
    logic              pwm_i;
    logic              enable;
    logic [FW-1:0]     filt_len;
    logic [CW-1:0]     period_o;
    logic [CW-1:0]     high_o;
    logic [DUTY_W-1:0] duty_o;
    logic              valid_o;
    logic              timeout_o;
    logic              overrun_o;
    logic              level_o;

    modport master (
        output pwm_i, enable, filt_len,
        input  period_o, high_o, duty_o, valid_o, timeout_o, overrun_o, level_o
    );

    modport slave (
        input  pwm_i, enable, filt_len,
        output period_o, high_o, duty_o, valid_o, timeout_o, overrun_o, level_o
    );
endinterface

// File: rtl/red_pitaya_pwm_div.sv
// Restoring divider producing floor(num * 2^DUTY_W / den), one quotient bit per cycle.
module red_pitaya_pwm_div
    import red_pitaya_pwm_pkg::*;
#(
    parameter int CW     = PWM_CW,
    parameter int DUTY_W = PWM_DUTY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              start,
    input  logic [CW-1:0]     num,
    input  logic [CW-1:0]     den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quot
);
    localparam int IW = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;

    logic [CW-1:0]     rem_q, rem_d;
    logic [CW-1:0]     den_q, den_d;
    logic [DUTY_W-1:0] quot_q, quot_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic [CW:0]       rem_x2;
    logic              ge;
    logic [DUTY_W-1:0] quot_step;
    logic              last;

    // num < den keeps the remainder below den, so 2*rem always fits in CW+1 bits.
    assign rem_x2    = {rem_q, 1'b0};
    assign ge        = rem_x2 >= {1'b0, den_q};
    assign quot_step = DUTY_W'({quot_q, ge});
    assign last      = cnt_q == IW'(DUTY_W - 1);

    assign busy = busy_q;
    assign done = busy_q & last;
    assign quot = quot_step;

    always_comb begin
        rem_d  = rem_q;
        den_d  = den_q;
        quot_d = quot_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (clr) begin
            rem_d  = '0;
            den_d  = '0;
            quot_d = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (start) begin
            rem_d  = num;
            den_d  = den;
            quot_d = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = ge ? CW'(rem_x2 - {1'b0, den_q}) : CW'(rem_x2);
            quot_d = quot_step;
            cnt_d  = cnt_q + IW'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            den_q  <= den_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/red_pitaya_pwm_capture.sv
// PWM input decoder: synchronize, deglitch, measure period/high time and derive a duty word.
//   state | meaning
//   IDLE  | waiting for the first rising edge, nothing measured yet
//   MEAS  | counting a full period between rising edges
//   STUCK | input held past counter saturation, timeout flagged
module red_pitaya_pwm_capture
    import red_pitaya_pwm_pkg::*;
#(
    parameter int CW     = PWM_CW,
    parameter int DUTY_W = PWM_DUTY_W,
    parameter int FW     = PWM_FW
) (
    input  logic clk,
    input  logic rst,
    red_pitaya_pwm_capture_if.slave bus
);
    localparam logic [CW-1:0] CNT_MAX = CW'(pwm_sat_val(CW));

    pwm_cap_state_t    state_q, state_d;
    logic              s1_q, s1_d, s2_q, s2_d;
    logic              filt_q, filt_d, filt_dly_q, filt_dly_d;
    logic [FW-1:0]     hold_q, hold_d;
    logic [CW-1:0]     period_cnt_q, period_cnt_d;
    logic [CW-1:0]     high_cnt_q, high_cnt_d;
    logic [CW-1:0]     per_sh_q, per_sh_d;
    logic [CW-1:0]     high_sh_q, high_sh_d;
    logic [CW-1:0]     period_o_q, period_o_d;
    logic [CW-1:0]     high_o_q, high_o_d;
    logic [DUTY_W-1:0] duty_o_q, duty_o_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;

    logic              rise;
    logic              sat;
    logic              div_start, div_busy, div_done;
    logic [DUTY_W-1:0] div_quot;

    assign rise = filt_q & ~filt_dly_q;

    red_pitaya_pwm_div #(
        .CW     (CW),
        .DUTY_W (DUTY_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .clr   (~bus.enable),
        .start (div_start),
        .num   (high_cnt_q),
        .den   (period_cnt_q),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    always_comb begin
        state_d      = state_q;
        s1_d         = bus.pwm_i;
        s2_d         = s1_q;
        filt_d       = filt_q;
        filt_dly_d   = filt_q;
        hold_d       = hold_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        per_sh_d     = per_sh_q;
        high_sh_d    = high_sh_q;
        period_o_d   = period_o_q;
        high_o_d     = high_o_q;
        duty_o_d     = duty_o_q;
        valid_d      = 1'b0;
        timeout_d    = timeout_q;
        overrun_d    = 1'b0;
        div_start    = 1'b0;
        sat          = 1'b0;

        if (s2_q == filt_q) begin
            hold_d = '0;
        end else if (hold_q == bus.filt_len) begin
            filt_d = s2_q;
            hold_d = '0;
        end else begin
            hold_d = hold_q + FW'(1);
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d      = MEAS;
                    period_cnt_d = CW'(1);
                    high_cnt_d   = CW'(1);
                end else if (period_cnt_q == CNT_MAX) begin
                    sat = 1'b1;
                end else begin
                    period_cnt_d = period_cnt_q + CW'(1);
                end
            end
            MEAS: begin
                // A rise on the saturation cycle still closes a valid period.
                if (rise) begin
                    if (div_busy) begin
                        overrun_d = 1'b1;
                    end else begin
                        div_start = 1'b1;
                        per_sh_d  = period_cnt_q;
                        high_sh_d = high_cnt_q;
                    end
                    period_cnt_d = CW'(1);
                    high_cnt_d   = CW'(1);
                end else if (period_cnt_q == CNT_MAX) begin
                    sat = 1'b1;
                end else begin
                    period_cnt_d = period_cnt_q + CW'(1);
                    high_cnt_d   = high_cnt_q + CW'(filt_q);
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d      = MEAS;
                    timeout_d    = 1'b0;
                    period_cnt_d = CW'(1);
                    high_cnt_d   = CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (sat) begin
            state_d    = STUCK;
            period_o_d = CNT_MAX;
            high_o_d   = filt_q ? CNT_MAX : '0;
            duty_o_d   = filt_q ? '1 : '0;
            valid_d    = 1'b1;
            timeout_d  = 1'b1;
        end

        if (div_done) begin
            period_o_d = per_sh_q;
            high_o_d   = high_sh_q;
            duty_o_d   = div_quot;
            valid_d    = 1'b1;
        end

        // Disable clears the measurement but keeps the last published result.
        if (!bus.enable) begin
            state_d      = IDLE;
            hold_d       = '0;
            period_cnt_d = '0;
            high_cnt_d   = '0;
            period_o_d   = period_o_q;
            high_o_d     = high_o_q;
            duty_o_d     = duty_o_q;
            valid_d      = 1'b0;
            timeout_d    = 1'b0;
            overrun_d    = 1'b0;
            div_start    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            filt_q       <= 1'b0;
            filt_dly_q   <= 1'b0;
            hold_q       <= '0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            per_sh_q     <= '0;
            high_sh_q    <= '0;
            period_o_q   <= '0;
            high_o_q     <= '0;
            duty_o_q     <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            filt_q       <= filt_d;
            filt_dly_q   <= filt_dly_d;
            hold_q       <= hold_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            per_sh_q     <= per_sh_d;
            high_sh_q    <= high_sh_d;
            period_o_q   <= period_o_d;
            high_o_q     <= high_o_d;
            duty_o_q     <= duty_o_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.period_o  = period_o_q;
    assign bus.high_o    = high_o_q;
    assign bus.duty_o    = duty_o_q;
    assign bus.valid_o   = valid_q;
    assign bus.timeout_o = timeout_q;
    assign bus.overrun_o = overrun_q;
    assign bus.level_o   = filt_q;

endmodule

// File: tb/tb_red_pitaya_pwm_capture.sv
// Scoreboard bench for the PWM capture block, run with an 8-bit counter so saturation is reachable.
module tb_red_pitaya_pwm_capture;
    import red_pitaya_pwm_pkg::*;

    localparam int CW = 8;
    localparam int DW = 8;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    red_pitaya_pwm_capture_if #(.CW(CW), .DUTY_W(DW), .FW(FW)) bus ();

    red_pitaya_pwm_capture #(.CW(CW), .DUTY_W(DW), .FW(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int per;
        int hi;
        int duty;
        int to;
        bit lat;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   rise_cyc = 0;
    int   ovr_cnt  = 0;
    logic lvl_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected result per valid_o pulse.
    always @(negedge clk) begin
        if (bus.level_o === 1'b1 && lvl_prev !== 1'b1) rise_cyc = cyc;
        lvl_prev = bus.level_o;
        if (bus.overrun_o === 1'b1) ovr_cnt++;
        if (bus.valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got period=%0d high=%0d duty=%0d, expected no valid",
                         bus.period_o, bus.high_o, bus.duty_o);
            end else begin
                e_m = sb.pop_front();
                chk("period", 32'(bus.period_o), 32'(e_m.per));
                chk("high", 32'(bus.high_o), 32'(e_m.hi));
                chk("duty", 32'(bus.duty_o), 32'(e_m.duty));
                chk("timeout_at_valid", 32'(bus.timeout_o), 32'(e_m.to));
                if (e_m.lat) chk("rise_to_valid", 32'(cyc - rise_cyc), 32'd9);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int h, input int l);
        bus.pwm_i = 1'b1;
        step(h);
        bus.pwm_i = 1'b0;
        step(l);
    endtask

    task automatic restart();
        bus.enable = 1'b0;
        step(2);
        bus.enable = 1'b1;
    endtask

    task automatic drain(input string nm);
        step(12);
        chk(nm, 32'(sb.size()), 32'd0);
    endtask

    task automatic push(input int per, input int hi, input int duty, input int to, input bit lat);
        exp_t e;
        e.per  = per;
        e.hi   = hi;
        e.duty = duty;
        e.to   = to;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    int   lat_k;
    int   ovr0;
    logic seen;

    initial begin
        rst          = 1'b1;
        bus.pwm_i    = 1'b0;
        bus.enable   = 1'b0;
        bus.filt_len = '0;
        step(3);
        chk("rst_period", 32'(bus.period_o), 32'd0);
        chk("rst_high", 32'(bus.high_o), 32'd0);
        chk("rst_duty", 32'(bus.duty_o), 32'd0);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_timeout", 32'(bus.timeout_o), 32'd0);
        chk("rst_overrun", 32'(bus.overrun_o), 32'd0);
        chk("rst_level", 32'(bus.level_o), 32'd0);
        rst = 1'b0;

        // 10 high / 30 low: 40-cycle period, duty floor(10*256/40)=64
        restart();
        for (int i = 0; i < 3; i++) push(40, 10, 64, 0, 1'b1);
        for (int i = 0; i < 4; i++) pulse(10, 30);
        drain("t1_drain");

        // Deglitch with filt_len=3
        bus.filt_len = 4'd3;
        restart();
        step(5);
        bus.pwm_i = 1'b1;
        step(2);
        bus.pwm_i = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            step(1);
            seen = seen | bus.level_o;
        end
        chk("glitch_level", 32'(seen), 32'd0);
        lat_k = -1;
        bus.pwm_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (k == 5) bus.pwm_i = 1'b0;
            if (bus.level_o === 1'b1 && lat_k < 0) lat_k = k;
        end
        chk("filter_latency", 32'(lat_k), 32'd6);
        drain("t2_drain");

        // Stuck high: saturate at 255, then recover
        bus.filt_len = '0;
        restart();
        push(255, 255, 255, 1, 1'b0);
        bus.pwm_i = 1'b1;
        step(270);
        chk("t3_stuck_drain", 32'(sb.size()), 32'd0);
        chk("timeout_set", 32'(bus.timeout_o), 32'd1);
        bus.pwm_i = 1'b0;
        step(20);
        bus.pwm_i = 1'b1;
        step(10);
        chk("timeout_clear", 32'(bus.timeout_o), 32'd0);
        push(30, 10, 85, 0, 1'b1);
        bus.pwm_i = 1'b0;
        step(20);
        pulse(10, 20);
        drain("t3_drain");

        // 6-cycle period, shorter than divider busy time
        restart();
        ovr0 = ovr_cnt;
        for (int i = 0; i < 3; i++) push(6, 2, 85, 0, 1'b0);
        for (int i = 0; i < 7; i++) pulse(2, 4);
        drain("t4_drain");
        chk("overrun_count", 32'(ovr_cnt - ovr0), 32'd3);

        // Disable mid-period: outputs hold, restart needs two rises
        restart();
        for (int i = 0; i < 3; i++) push(40, 10, 64, 0, 1'b1);
        for (int i = 0; i < 3; i++) pulse(10, 30);
        pulse(10, 10);
        bus.enable = 1'b0;
        step(20);
        bus.enable = 1'b1;
        step(1);
        chk("hold_period", 32'(bus.period_o), 32'd40);
        chk("hold_high", 32'(bus.high_o), 32'd10);
        chk("hold_duty", 32'(bus.duty_o), 32'd64);
        for (int i = 0; i < 2; i++) push(16, 5, 80, 0, 1'b1);
        for (int i = 0; i < 3; i++) pulse(5, 11);
        drain("t5_drain");

        // Reset during a division
        restart();
        pulse(10, 30);
        bus.pwm_i = 1'b1;
        step(6);
        rst = 1'b1;
        step(1);
        chk("rst_mid_period", 32'(bus.period_o), 32'd0);
        chk("rst_mid_high", 32'(bus.high_o), 32'd0);
        chk("rst_mid_duty", 32'(bus.duty_o), 32'd0);
        chk("rst_mid_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_mid_timeout", 32'(bus.timeout_o), 32'd0);
        chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        bus.pwm_i = 1'b0;
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
